// File: rtl/iir_coeff_ctrl.sv
// iir_coeff_ctrl: shadow coefficient bank for the IIR notch stage.
// Writes land in a shadow bank over a request/ready port. A commit waits for
// a gap in the sample stream, or gives up after GAP_TIMEOUT cycles, and then
// pulses coeff_wr_en for one cycle so the filter takes the whole bank at once.
// After that, bypass is held for SETTLE_SAMPLES samples to hide the transient.
module iir_coeff_ctrl #(
    parameter int COEFF_WIDTH    = 20,
    parameter int COEFF_DEPTH    = 5,
    parameter int ADDR_WIDTH     = 4,
    parameter int GAP_TIMEOUT    = 16,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    cfg_valid_i,
    output logic                                    cfg_ready_o,
    input  logic                                    cfg_write_i,
    input  logic [ADDR_WIDTH-1:0]                   cfg_addr_i,
    input  logic [COEFF_WIDTH-1:0]                  cfg_wdata_i,
    output logic [COEFF_WIDTH-1:0]                  cfg_rdata_o,
    output logic                                    cfg_rvalid_o,
    output logic                                    cfg_err_o,
    input  logic                                    commit_req_i,
    output logic                                    busy_o,
    output logic                                    commit_done_o,
    output logic                                    commit_forced_o,
    input  logic                                    sample_valid_i,
    input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_live_i,
    output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_shadow_o,
    output logic                                    coeff_wr_en_o,
    output logic                                    bypass_o
);

    // The live-coefficient window sits at 8; the copy command is the top address.
    localparam int LIVE_BASE = 8;
    localparam logic [ADDR_WIDTH-1:0] COPY_ADDR = {ADDR_WIDTH{1'b1}};

    // One counter serves both the gap timeout and the settle sample count.
    localparam int CNT_MAX = (GAP_TIMEOUT > SETTLE_SAMPLES) ? GAP_TIMEOUT : SETTLE_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GAP = 2'd1,
        S_SETTLE   = 2'd2
    } state_t;

    state_t                                  state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic                                    done_q, done_d;
    logic                                    forced_q, forced_d;
    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow_q, shadow_d;
    logic [COEFF_WIDTH-1:0]                  rdata_q, rdata_d;
    logic                                    rvalid_q, rvalid_d;
    logic                                    err_q, err_d;

    // Address decode results
    logic [COEFF_DEPTH-1:0]  sh_sel;
    logic                    sh_hit;
    logic                    live_hit;
    logic                    is_copy;
    logic [COEFF_WIDTH-1:0]  rd_val;
    logic                    access_ok;
    logic                    accept;

    // Decode the config address into shadow/live/copy hits and the read value.
    always_comb begin
        sh_sel   = '0;
        sh_hit   = 1'b0;
        live_hit = 1'b0;
        rd_val   = '0;
        for (int i = 0; i < COEFF_DEPTH; i++) begin
            if (cfg_addr_i == ADDR_WIDTH'(i)) begin
                sh_sel[i] = 1'b1;
                sh_hit    = 1'b1;
                rd_val    = shadow_q[i];
            end
            if (cfg_addr_i == ADDR_WIDTH'(LIVE_BASE + i)) begin
                live_hit = 1'b1;
                rd_val   = coeff_live_i[i];
            end
        end
        is_copy   = (cfg_addr_i == COPY_ADDR);
        // Shadow is R/W, live is read-only, copy is write-only; anything else faults.
        access_ok = cfg_write_i ? (sh_hit || is_copy) : (sh_hit || live_hit);
        accept    = cfg_valid_i && cfg_ready_o;
    end

    // Shadow bank next state: only accepted, legal writes or the copy command touch it.
    always_comb begin
        shadow_d = shadow_q;
        if (accept && cfg_write_i && access_ok) begin
            if (is_copy) begin
                shadow_d = coeff_live_i;
            end else begin
                for (int i = 0; i < COEFF_DEPTH; i++) begin
                    if (sh_sel[i]) begin
                        shadow_d[i] = cfg_wdata_i;
                    end
                end
            end
        end
    end

    // Response path: read data, read-valid and error are all one cycle after acceptance.
    always_comb begin
        rvalid_d = accept && !cfg_write_i;
        err_d    = accept && !access_ok;
        rdata_d  = '0;
        if (accept && !cfg_write_i && access_ok) begin
            rdata_d = rd_val;
        end
    end

    // Commit sequencer: next state and the combinational strobes for the filter.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        forced_d      = forced_q;
        cfg_ready_o   = 1'b0;
        busy_o        = 1'b0;
        coeff_wr_en_o = 1'b0;
        bypass_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready_o = 1'b1;
                if (commit_req_i) begin
                    state_d = S_WAIT_GAP;
                    cnt_d   = '0;
                end
            end
            S_WAIT_GAP: begin
                busy_o = 1'b1;
                // Commit in a sample gap, or force it once the timeout is reached.
                if (!sample_valid_i || (cnt_q == GAP_LAST)) begin
                    coeff_wr_en_o = 1'b1;
                    forced_d      = sample_valid_i;
                    cnt_d         = '0;
                    if (SETTLE_SAMPLES == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                busy_o   = 1'b1;
                bypass_o = 1'b1;
                if (sample_valid_i) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and register file update, synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            forced_q <= 1'b0;
            shadow_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            forced_q <= forced_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign coeff_shadow_o  = shadow_q;
    assign cfg_rdata_o     = rdata_q;
    assign cfg_rvalid_o    = rvalid_q;
    assign cfg_err_o       = err_q;
    assign commit_done_o   = done_q;
    assign commit_forced_o = forced_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl: register access, gap/forced commits,
// settle masking, error decode, copy command and reset during a commit.
module tb_iir_coeff_ctrl;
    localparam int W  = 20;
    localparam int D  = 5;
    localparam int AW = 4;

    typedef logic [D-1:0][W-1:0] bank_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready, cfg_write;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_wdata, cfg_rdata;
    logic          cfg_rvalid, cfg_err;
    logic          commit_req, busy, commit_done, commit_forced;
    logic          sample_valid;
    bank_t         coeff_live, coeff_shadow;
    logic          coeff_wr_en, bypass;

    int checks   = 0;
    int failures = 0;
    bank_t exp_sh;
    bank_t live_def;
    logic [W-1:0] wvals [D];

    always #5 clk = ~clk;

    iir_coeff_ctrl #(
        .COEFF_WIDTH(W), .COEFF_DEPTH(D), .ADDR_WIDTH(AW),
        .GAP_TIMEOUT(16), .SETTLE_SAMPLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_write_i(cfg_write),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
        .cfg_rvalid_o(cfg_rvalid), .cfg_err_o(cfg_err),
        .commit_req_i(commit_req), .busy_o(busy), .commit_done_o(commit_done),
        .commit_forced_o(commit_forced), .sample_valid_i(sample_valid),
        .coeff_live_i(coeff_live), .coeff_shadow_o(coeff_shadow),
        .coeff_wr_en_o(coeff_wr_en), .bypass_o(bypass)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_go(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        cfg_valid = 1'b1; cfg_write = wr; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({cfg_ready, busy, cfg_rvalid, cfg_err, commit_done, commit_forced, coeff_wr_en, bypass} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 10000000",
                     {cfg_ready, busy, cfg_rvalid, cfg_err, commit_done, commit_forced, coeff_wr_en, bypass});
        end
        checks++;
        if (coeff_shadow !== '0) begin
            failures++; $display("FAIL reset_shadow got %h exp 0", coeff_shadow);
        end
        checks++;
        if (cfg_rdata !== '0) begin
            failures++; $display("FAIL reset_rdata got %h exp 0", cfg_rdata);
        end
        exp_sh = '0;
    endtask

    task automatic test_write_read();
        for (int i = 0; i < D; i++) begin
            cfg_go(1'b1, AW'(i), wvals[i]);
            exp_sh[i] = wvals[i];
            checks++;
            if (cfg_err !== 1'b0 || cfg_rvalid !== 1'b0) begin
                failures++; $display("FAIL wr_resp addr %0d got err=%b rvalid=%b exp 0 0", i, cfg_err, cfg_rvalid);
            end
        end
        for (int i = 0; i < D; i++) begin
            cfg_go(1'b0, AW'(i), '0);
            checks++;
            if (cfg_rvalid !== 1'b1 || cfg_err !== 1'b0 || cfg_rdata !== wvals[i]) begin
                failures++;
                $display("FAIL rd_back addr %0d got rvalid=%b err=%b data=%h exp 1 0 %h",
                         i, cfg_rvalid, cfg_err, cfg_rdata, wvals[i]);
            end
        end
        tick();
        checks++;
        if (cfg_rvalid !== 1'b0) begin
            failures++; $display("FAIL rvalid_pulse got %b exp 0", cfg_rvalid);
        end
    endtask

    task automatic test_commit_gap();
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        tick();
        commit_req = 1'b0;
        checks++;
        if (coeff_wr_en !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++; $display("FAIL gap_wr_en got wr=%b busy=%b rdy=%b exp 1 1 0", coeff_wr_en, busy, cfg_ready);
        end
        checks++;
        if (coeff_shadow !== exp_sh) begin
            failures++; $display("FAIL gap_shadow got %h exp %h", coeff_shadow, exp_sh);
        end
        tick();
        checks++;
        if (coeff_wr_en !== 1'b0 || bypass !== 1'b1 || commit_forced !== 1'b0) begin
            failures++; $display("FAIL gap_settle got wr=%b byp=%b forced=%b exp 0 1 0", coeff_wr_en, bypass, commit_forced);
        end
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            checks++;
            if (k < 3) begin
                if (bypass !== 1'b1 || commit_done !== 1'b0) begin
                    failures++; $display("FAIL settle_%0d got byp=%b done=%b exp 1 0", k, bypass, commit_done);
                end
            end else begin
                if (bypass !== 1'b0 || commit_done !== 1'b1 || busy !== 1'b0) begin
                    failures++; $display("FAIL settle_end got byp=%b done=%b busy=%b exp 0 1 0", bypass, commit_done, busy);
                end
            end
        end
        tick();
        checks++;
        if (commit_done !== 1'b0) begin
            failures++; $display("FAIL done_pulse got %b exp 0", commit_done);
        end
    endtask

    task automatic test_forced();
        int n;
        sample_valid = 1'b1;
        commit_req   = 1'b1;
        tick();
        commit_req = 1'b0;
        n = 1;
        while (coeff_wr_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL forced_latency got %0d exp 16", n);
        end
        tick();
        checks++;
        if (commit_forced !== 1'b1 || coeff_wr_en !== 1'b0 || bypass !== 1'b1) begin
            failures++; $display("FAIL forced_flag got forced=%b wr=%b byp=%b exp 1 0 1", commit_forced, coeff_wr_en, bypass);
        end
        // sample_valid still high: four cycles finish the settle.
        tick(); tick(); tick(); tick();
        sample_valid = 1'b0;
        checks++;
        if (commit_done !== 1'b1 || bypass !== 1'b0) begin
            failures++; $display("FAIL forced_done got done=%b byp=%b exp 1 0", commit_done, bypass);
        end
        tick();
    endtask

    task automatic test_errors();
        cfg_go(1'b1, 4'd9, 20'h12345);
        checks++;
        if (cfg_err !== 1'b1 || cfg_rvalid !== 1'b0) begin
            failures++; $display("FAIL err_wr9 got err=%b rvalid=%b exp 1 0", cfg_err, cfg_rvalid);
        end
        cfg_go(1'b0, 4'd6, '0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_rvalid !== 1'b1 || cfg_rdata !== '0) begin
            failures++; $display("FAIL err_rd6 got err=%b rvalid=%b data=%h exp 1 1 0", cfg_err, cfg_rvalid, cfg_rdata);
        end
        cfg_go(1'b1, 4'd5, 20'hABCDE);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++; $display("FAIL err_wr5 got %b exp 1", cfg_err);
        end
        cfg_go(1'b0, 4'd15, '0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_rdata !== '0) begin
            failures++; $display("FAIL err_rd15 got err=%b data=%h exp 1 0", cfg_err, cfg_rdata);
        end
        checks++;
        if (coeff_shadow !== exp_sh) begin
            failures++; $display("FAIL err_shadow got %h exp %h", coeff_shadow, exp_sh);
        end
        cfg_go(1'b0, 4'd10, '0);
        checks++;
        if (cfg_err !== 1'b0 || cfg_rvalid !== 1'b1 || cfg_rdata !== live_def[2]) begin
            failures++; $display("FAIL rd_live10 got err=%b rvalid=%b data=%h exp 0 1 %h", cfg_err, cfg_rvalid, cfg_rdata, live_def[2]);
        end
    endtask

    task automatic test_same_cycle();
        // Write and commit request in the same IDLE cycle: the write must be committed.
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        cfg_go(1'b1, 4'd2, 20'h0BEEF);
        commit_req = 1'b0;
        exp_sh[2] = 20'h0BEEF;
        checks++;
        if (coeff_wr_en !== 1'b1 || coeff_shadow !== exp_sh) begin
            failures++; $display("FAIL same_cycle got wr=%b shadow=%h exp 1 %h", coeff_wr_en, coeff_shadow, exp_sh);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        end
        checks++;
        if (commit_done !== 1'b1) begin
            failures++; $display("FAIL same_cycle_done got %b exp 1", commit_done);
        end
        tick();
    endtask

    task automatic test_copy();
        rst = 1'b1; tick(); rst = 1'b0;
        exp_sh = '0;
        cfg_go(1'b1, 4'd15, 20'hFFFFF);
        exp_sh = live_def;
        checks++;
        if (cfg_err !== 1'b0 || coeff_shadow !== exp_sh) begin
            failures++; $display("FAIL copy got err=%b shadow=%h exp 0 %h", cfg_err, coeff_shadow, exp_sh);
        end
        cfg_go(1'b0, 4'd1, '0);
        checks++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 20'h5907C) begin
            failures++; $display("FAIL copy_rd1 got rvalid=%b data=%h exp 1 5907c", cfg_rvalid, cfg_rdata);
        end
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        // In SETTLE: a commit request and a config request must both be refused.
        commit_req = 1'b1;
        cfg_valid  = 1'b1; cfg_write = 1'b1; cfg_addr = 4'd0; cfg_wdata = 20'h11111;
        checks++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1 || bypass !== 1'b1) begin
            failures++; $display("FAIL settle_busy got rdy=%b busy=%b byp=%b exp 0 1 1", cfg_ready, busy, bypass);
        end
        tick();
        commit_req = 1'b0;
        cfg_valid  = 1'b0; cfg_write = 1'b0; cfg_wdata = '0;
        checks++;
        if (coeff_shadow !== exp_sh || cfg_err !== 1'b0 || bypass !== 1'b1) begin
            failures++; $display("FAIL settle_refuse got shadow=%h err=%b byp=%b exp %h 0 1", coeff_shadow, cfg_err, bypass, exp_sh);
        end
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        end
        checks++;
        if (commit_done !== 1'b1) begin
            failures++; $display("FAIL copy_done got %b exp 1", commit_done);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || coeff_wr_en !== 1'b0) begin
            failures++; $display("FAIL no_queue got busy=%b wr=%b exp 0 0", busy, coeff_wr_en);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bypass !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || coeff_shadow !== '0 || commit_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got byp=%b busy=%b rdy=%b done=%b shadow=%h exp 0 0 1 0 0",
                     bypass, busy, cfg_ready, commit_done, coeff_shadow);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            sample_valid = 1'b1; tick();
            if (commit_done === 1'b1) seen++;
        end
        sample_valid = 1'b0;
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL reset_mid_done got %0d exp 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        commit_req = 1'b0; sample_valid = 1'b0;
        wvals[0] = 20'h37061; wvals[1] = 20'hC8F9F; wvals[2] = 20'h37061;
        wvals[3] = 20'hC8F9F; wvals[4] = 20'h2E0C3;
        live_def[0] = 20'h2C83E; live_def[1] = 20'h5907C; live_def[2] = 20'h2C83E;
        live_def[3] = 20'hA8E4A; live_def[4] = 20'h1A7B1;
        coeff_live = live_def;
        exp_sh = '0;

        test_reset();
        test_write_read();
        test_commit_gap();
        test_forced();
        test_errors();
        test_same_cycle();
        test_copy();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
